// File: rtl/bridge_pkg.sv
// Shared constants for the CPU data-memory bridge: MMIO page, register offsets, 7-seg lookup.
package bridge_pkg;
    localparam logic [19:0] MMIO_PAGE = 20'hFFFFF;

    localparam logic [11:0] OFF_DISP  = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_PRESC = 12'h024;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;

    // Index n gives the active-low {dp,g,f,e,d,c,b,a} pattern for hex digit n.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };
endpackage

// File: rtl/dmem_bridge_seg_scan.sv
// Eight-digit multiplexed 7-segment scanner; one digit slot lasts SCAN_DIV clocks.
module seg_scan
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV = 25000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_disp,
    output logic [7:0]  o_dig_en,
    output logic [7:0]  o_seg
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_dig;
    logic [3:0]    w_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_dig <= '0;
        end else if (r_cnt == CW'(SCAN_DIV - 1)) begin
            r_cnt <= '0;
            r_dig <= r_dig + 3'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_nib    = i_disp[{r_dig, 2'b00} +: 4];
    assign o_dig_en = ~(8'b1 << r_dig);
    assign o_seg    = SEG_LUT[w_nib];
endmodule

// File: rtl/dmem_bridge.sv
// CPU data bus splitter: DRAM for normal addresses, MMIO page 0xFFFFF000 for board peripherals.
// Define DMEM_BRIDGE_TIMER_EN to build the timer/prescale registers.
module dmem_bridge
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV = 25000,
    parameter int DRAM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        addr,
    input  logic               we,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         seg
);
    logic        w_mmio, w_wr;
    logic [11:0] w_off;
    logic [31:0] r_disp;
    logic [23:0] r_led, r_sw_meta, r_sw_sync;
    logic [31:0] w_timer, w_presc;

    assign w_mmio     = (addr[31:12] == MMIO_PAGE);
    assign w_off      = addr[11:0];
    assign w_wr       = we & w_mmio;
    assign dram_addr  = addr[DRAM_AW+1:2];
    assign dram_we    = we & ~w_mmio;
    assign dram_wdata = wdata;
    assign led        = r_led;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp    <= '0;
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (w_wr && w_off == OFF_DISP) r_disp <= wdata;
            if (w_wr && w_off == OFF_LED)  r_led  <= wdata[23:0];
        end
    end

`ifdef DMEM_BRIDGE_TIMER_EN
    logic [31:0] r_timer, r_presc, r_pc;
    logic        w_tick;

    assign w_tick = (r_pc == r_presc);

    // A timer or prescale write restarts the prescale period from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
            r_presc <= '0;
            r_pc    <= '0;
        end else begin
            if (w_wr && w_off == OFF_TIMER) begin
                r_timer <= wdata;
                r_pc    <= '0;
            end else if (w_wr && w_off == OFF_PRESC) begin
                r_presc <= wdata;
                r_pc    <= '0;
                if (w_tick) r_timer <= r_timer + 32'd1;
            end else if (w_tick) begin
                r_timer <= r_timer + 32'd1;
                r_pc    <= '0;
            end else begin
                r_pc    <= r_pc + 32'd1;
            end
        end
    end

    assign w_timer = r_timer;
    assign w_presc = r_presc;
`else
    assign w_timer = '0;
    assign w_presc = '0;
`endif

    always_comb begin
        rdata = dram_rdata;
        if (w_mmio) begin
            case (w_off)
                OFF_DISP:  rdata = r_disp;
                OFF_TIMER: rdata = w_timer;
                OFF_PRESC: rdata = w_presc;
                OFF_LED:   rdata = {8'h00, r_led};
                OFF_SW:    rdata = {8'h00, r_sw_sync};
                default:   rdata = '0;
            endcase
        end
    end

    seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_disp   (r_disp),
        .o_dig_en (dig_en),
        .o_seg    (seg)
    );
endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: address decode table plus LED, switch, scan, timer and reset sequences.
module tb_dmem_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata, rdata, dram_wdata, dram_rdata;
    logic        we, dram_we;
    logic [13:0] dram_addr;
    logic [23:0] sw, led;
    logic [7:0]  dig_en, seg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_bridge #(.SCAN_DIV(4), .DRAM_AW(14)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
        .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata), .sw(sw), .led(led), .dig_en(dig_en), .seg(seg)
    );

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] wd;
        logic [31:0] drd;
        logic [31:0] exp_rd;
        logic        exp_dwe;
        logic [13:0] exp_daddr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0010, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 14'h0004};
        vecs[1] = '{32'h0000_0010, 1'b0, 32'h0,         32'h0000_0011, 32'h0000_0011, 1'b0, 14'h0004};
        vecs[2] = '{32'hFFFF_F060, 1'b1, 32'h00AB_CDEF, 32'h0000_CAFE, 32'h0,         1'b0, 14'h3C18};
        vecs[3] = '{32'hFFFF_F0FC, 1'b0, 32'h0,         32'h0000_1234, 32'h0,         1'b0, 14'h3C3F};
        vecs[4] = '{32'hFFFF_E000, 1'b1, 32'h5555_AAAA, 32'h0000_0077, 32'h0000_0077, 1'b1, 14'h3800};
        vecs[5] = '{32'h0000_FFFC, 1'b0, 32'h0,         32'h0000_A5A5, 32'h0000_A5A5, 1'b0, 14'h3FFF};
        vecs[6] = '{32'hFFFF_F070, 1'b1, 32'hFFFF_FFFF, 32'h0000_0009, 32'h0,         1'b0, 14'h3C1C};
        vecs[7] = '{32'hFFFF_F000, 1'b0, 32'h0,         32'h0000_0003, 32'h0,         1'b0, 14'h3C00};

        rst_n = 1'b0; addr = '0; we = 1'b0; wdata = '0; dram_rdata = '0; sw = '0;
        #1;
        check("reset_dig_en", {24'h0, dig_en}, 32'hFE);
        check("reset_seg", {24'h0, seg}, 32'hC0);
        check("reset_led", {8'h0, led}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Combinational decode; writes are withdrawn before the next rising edge.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            addr = vecs[i].a; we = vecs[i].w; wdata = vecs[i].wd; dram_rdata = vecs[i].drd;
            #1;
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
            check($sformatf("v%0d_dram_we", i), {31'h0, dram_we}, {31'h0, vecs[i].exp_dwe});
            check($sformatf("v%0d_dram_addr", i), {18'h0, dram_addr}, {18'h0, vecs[i].exp_daddr});
            check($sformatf("v%0d_dram_wdata", i), dram_wdata, vecs[i].wd);
            #1 we = 1'b0;
        end

        mmio_wr(32'hFFFF_F060, 32'h00AB_CDEF);
        check("led_after_write", {8'h0, led}, 32'h00AB_CDEF);
        addr = 32'hFFFF_F060;
        #1 check("led_readback", rdata, 32'h00AB_CDEF);
        mmio_wr(32'hFFFF_F070, 32'h0000_1111);
        mmio_wr(32'hFFFF_F0FC, 32'h0000_2222);
        addr = 32'hFFFF_F070;
        #1 check("sw_write_ignored", rdata, 32'h0);
        mmio_wr(32'hFFFF_F000, 32'h8765_4321);
        addr = 32'hFFFF_F000;
        #1 check("disp_readback", rdata, 32'h8765_4321);

        @(negedge clk) sw = 24'h00F00F; addr = 32'hFFFF_F070;
        edges(1);
        check("sw_one_edge", rdata, 32'h0);
        edges(1);
        check("sw_two_edges", rdata, 32'h0000_F00F);
        addr = 32'hFFFF_F0FC;
        #1 check("unmapped_read", rdata, 32'h0);

`ifdef DMEM_BRIDGE_TIMER_EN
        mmio_wr(32'hFFFF_F024, 32'd2);
        mmio_wr(32'hFFFF_F020, 32'hFFFF_FFFE);
        addr = 32'hFFFF_F024;
        #1 check("presc_readback", rdata, 32'd2);
        addr = 32'hFFFF_F020;
        #1 check("timer_loaded", rdata, 32'hFFFF_FFFE);
        edges(2);
        check("timer_hold_2", rdata, 32'hFFFF_FFFE);
        edges(1);
        check("timer_tick_3", rdata, 32'hFFFF_FFFF);
        edges(2);
        check("timer_hold_5", rdata, 32'hFFFF_FFFF);
        edges(1);
        check("timer_wrap_6", rdata, 32'h0);
        edges(2);
        mmio_wr(32'hFFFF_F020, 32'h0000_0055);
        addr = 32'hFFFF_F020;
        #1 check("timer_write_wins", rdata, 32'h0000_0055);
        edges(2);
        check("timer_after_write_2", rdata, 32'h0000_0055);
        edges(1);
        check("timer_after_write_3", rdata, 32'h0000_0056);
`else
        mmio_wr(32'hFFFF_F020, 32'h0000_0005);
        mmio_wr(32'hFFFF_F024, 32'h0000_0007);
        addr = 32'hFFFF_F020;
        #1 check("timer_absent", rdata, 32'h0);
        addr = 32'hFFFF_F024;
        #1 check("presc_absent", rdata, 32'h0);
`endif

        // Asynchronous reset mid-scan with LED and display holding data.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dig_en", {24'h0, dig_en}, 32'hFE);
        check("arst_seg", {24'h0, seg}, 32'hC0);
        check("arst_led", {8'h0, led}, 32'h0);
        addr = 32'h0000_0020; we = 1'b1;
        #1 check("arst_dram_we", {31'h0, dram_we}, 32'h1);
        we = 1'b0;

        @(negedge clk);
        rst_n = 1'b1; addr = 32'hFFFF_F000; wdata = 32'h0000_000A; we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
        check("scan_e1_dig", {24'h0, dig_en}, 32'hFE);
        check("scan_e1_seg", {24'h0, seg}, 32'h88);
        edges(2);
        check("scan_e3_dig", {24'h0, dig_en}, 32'hFE);
        check("scan_e3_seg", {24'h0, seg}, 32'h88);
        edges(1);
        check("scan_e4_dig", {24'h0, dig_en}, 32'hFD);
        check("scan_e4_seg", {24'h0, seg}, 32'hC0);
        edges(27);
        check("scan_e31_dig", {24'h0, dig_en}, 32'h7F);
        edges(1);
        check("scan_e32_dig", {24'h0, dig_en}, 32'hFE);
        check("scan_e32_seg", {24'h0, seg}, 32'h88);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
